// File: rtl/key_debounce_if.sv
// Key debouncer signal bundle: raw key line in, clean level and edge pulses out.
// The board-side driver uses master; the debouncer uses slave.
interface key_debounce_if;
  logic key_i;
  logic level_o;
  logic rise_o;
  logic fall_o;

  modport master (output key_i, input level_o, input rise_o, input fall_o);
  modport slave  (input key_i, output level_o, output rise_o, output fall_o);
endinterface

// File: rtl/key_debounce.sv
// Synchronising key debouncer: a flop chain brings the raw key into clk_i,
// then a four-state FSM accepts a new level after DEBOUNCE_CYCLES agreeing samples.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   STABLE_LOW  | level 0 accepted, waiting for a differing sample
//   CHECK_HIGH  | level 0, counting consecutive high samples
//   STABLE_HIGH | level 1 accepted, waiting for a differing sample
//   CHECK_LOW   | level 1, counting consecutive low samples
module key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int INVERT          = 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  key_debounce_if.slave  bus
);

  localparam int             CW       = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           IDLE_RAW = (INVERT != 0);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 s;
  logic                 level_q, rise_q, fall_q;
  logic                 level_d, rise_d, fall_d;

  // Reset loads the idle raw value so leaving reset never looks like an edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{IDLE_RAW}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.key_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ IDLE_RAW;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LOW: begin
        cnt_d = '0;
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_HIGH;
          end else begin
            state_d = CHECK_HIGH;
            cnt_d   = CW'(1);
          end
        end
      end
      CHECK_HIGH: begin
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE_HIGH: begin
        cnt_d = '0;
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_LOW;
          end else begin
            state_d = CHECK_LOW;
            cnt_d   = CW'(1);
          end
        end
      end
      CHECK_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulses only on a real acceptance; a bounce back into the old stable state is silent.
  always_comb begin
    level_d = (state_d == STABLE_HIGH) || (state_d == CHECK_LOW);
    rise_d  = (state_d == STABLE_HIGH) &&
              ((state_q == CHECK_HIGH) || (state_q == STABLE_LOW));
    fall_d  = (state_d == STABLE_LOW) &&
              ((state_q == CHECK_LOW) || (state_q == STABLE_HIGH));
  end

  assign bus.level_o = level_q;
  assign bus.rise_o  = rise_q;
  assign bus.fall_o  = fall_q;

endmodule
